// File: rtl/uart_fifo_bridge.sv
// CPU-side UART port: RX/TX byte FIFOs, status/control registers and a transmit launcher.
// Optional interrupt logic is compiled in when UART_BRIDGE_IRQ_EN is defined.
module uart_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_addr,
  input  logic       io_rd,
  input  logic       io_wr,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  input  logic [7:0] rx_byte,
  input  logic       received,
  input  logic       recv_error,
  input  logic       is_transmitting,
  output logic [7:0] tx_byte,
  output logic       transmit,
  output logic       irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    L_IDLE      = 2'd0,
    L_WAIT_BUSY = 2'd1,
    L_WAIT_DONE = 2'd2
  } launch_state_t;

  logic [7:0]    rx_mem_r [DEPTH];
  logic [7:0]    tx_mem_r [DEPTH];
  logic [PW-1:0] rx_wptr_r;
  logic [PW-1:0] rx_rptr_r;
  logic [PW-1:0] tx_wptr_r;
  logic [PW-1:0] tx_rptr_r;
  logic          rx_overrun_r;
  logic          rx_error_r;
  logic          tx_overflow_r;
  launch_state_t state_r;
  launch_state_t next_state_s;

  logic       data_rd_s;
  logic       stat_rd_s;
  logic       data_wr_s;
  logic       rx_empty_s;
  logic       rx_full_s;
  logic       tx_empty_s;
  logic       tx_full_s;
  logic       rx_pop_s;
  logic       rx_push_s;
  logic       rx_overrun_set_s;
  logic       tx_pop_s;
  logic       tx_push_s;
  logic       tx_overflow_set_s;
  logic       tx_idle_s;
  logic       launch_s;
  logic [7:0] rx_head_s;
  logic [7:0] tx_head_s;
  logic [7:0] status_s;

  assign data_rd_s = io_rd & ~io_addr;
  assign stat_rd_s = io_rd & io_addr;
  assign data_wr_s = io_wr & ~io_addr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rx_empty_s = (rx_wptr_r == rx_rptr_r);
  assign rx_full_s  = (rx_wptr_r[PW-1] != rx_rptr_r[PW-1]) &&
                      (rx_wptr_r[PW-2:0] == rx_rptr_r[PW-2:0]);
  assign tx_empty_s = (tx_wptr_r == tx_rptr_r);
  assign tx_full_s  = (tx_wptr_r[PW-1] != tx_rptr_r[PW-1]) &&
                      (tx_wptr_r[PW-2:0] == tx_rptr_r[PW-2:0]);

  assign rx_head_s = rx_mem_r[rx_rptr_r[DEPTH_LOG2-1:0]];
  assign tx_head_s = tx_mem_r[tx_rptr_r[DEPTH_LOG2-1:0]];
  assign tx_idle_s = tx_empty_s && (state_r == L_IDLE);

  assign status_s = {2'b00, tx_overflow_r, tx_idle_s, rx_error_r,
                     rx_overrun_r, ~tx_full_s, ~rx_empty_s};

  // FIFO push/pop qualification; a pop frees the slot for a same-cycle push.
  always_comb begin
    rx_pop_s          = 1'b0;
    rx_push_s         = 1'b0;
    rx_overrun_set_s  = 1'b0;
    tx_push_s         = 1'b0;
    tx_overflow_set_s = 1'b0;
    if (data_rd_s && !rx_empty_s) begin
      rx_pop_s = 1'b1;
    end else begin
      rx_pop_s = 1'b0;
    end
    if (received) begin
      rx_push_s        = !rx_full_s || rx_pop_s;
      rx_overrun_set_s = rx_full_s && !rx_pop_s;
    end else begin
      rx_push_s        = 1'b0;
      rx_overrun_set_s = 1'b0;
    end
    if (data_wr_s) begin
      tx_push_s         = !tx_full_s || tx_pop_s;
      tx_overflow_set_s = tx_full_s && !tx_pop_s;
    end else begin
      tx_push_s         = 1'b0;
      tx_overflow_set_s = 1'b0;
    end
  end

  // FIFO storage writes; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (rx_push_s) begin
      rx_mem_r[rx_wptr_r[DEPTH_LOG2-1:0]] <= rx_byte;
    end
    if (tx_push_s) begin
      tx_mem_r[tx_wptr_r[DEPTH_LOG2-1:0]] <= io_wdata;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_r <= '0;
      rx_rptr_r <= '0;
      tx_wptr_r <= '0;
      tx_rptr_r <= '0;
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PTR_ONE;
      if (tx_push_s) tx_wptr_r <= tx_wptr_r + PTR_ONE;
      if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PTR_ONE;
    end
  end

  // Sticky flags clear on a status read; a same-cycle set wins so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overrun_r  <= 1'b0;
      rx_error_r    <= 1'b0;
      tx_overflow_r <= 1'b0;
    end else begin
      rx_overrun_r  <= rx_overrun_set_s  | (rx_overrun_r  & ~stat_rd_s);
      rx_error_r    <= recv_error        | (rx_error_r    & ~stat_rd_s);
      tx_overflow_r <= tx_overflow_set_s | (tx_overflow_r & ~stat_rd_s);
    end
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_rdata <= 8'h00;
    end else if (data_rd_s) begin
      io_rdata <= rx_empty_s ? 8'h00 : rx_head_s;
    end else if (stat_rd_s) begin
      io_rdata <= status_s;
    end
  end

  // Launcher state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= L_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Launcher next state: one request per byte, then track the UART busy window.
  always_comb begin
    next_state_s = state_r;
    launch_s     = 1'b0;
    case (state_r)
      L_IDLE: begin
        if (!tx_empty_s && !is_transmitting) begin
          launch_s     = 1'b1;
          next_state_s = L_WAIT_BUSY;
        end else begin
          next_state_s = L_IDLE;
        end
      end
      L_WAIT_BUSY: begin
        if (is_transmitting) begin
          next_state_s = L_WAIT_DONE;
        end else begin
          next_state_s = L_WAIT_BUSY;
        end
      end
      L_WAIT_DONE: begin
        if (!is_transmitting) begin
          next_state_s = L_IDLE;
        end else begin
          next_state_s = L_WAIT_DONE;
        end
      end
      default: begin
        next_state_s = L_IDLE;
      end
    endcase
  end

  assign tx_pop_s = launch_s;

  // Registered UART transmit handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      transmit <= launch_s;
      if (launch_s) begin
        tx_byte <= tx_head_s;
      end
    end
  end

`ifdef UART_BRIDGE_IRQ_EN
  logic rxie_r;
  logic txie_r;
  logic ctrl_wr_s;

  assign ctrl_wr_s = io_wr & io_addr;

  // Control register and registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxie_r <= 1'b0;
      txie_r <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        rxie_r <= io_wdata[0];
        txie_r <= io_wdata[1];
      end
      irq <= (rxie_r & ~rx_empty_s) | (txie_r & tx_idle_s);
    end
  end
`else
  // Interrupt disabled in this build.
  always_ff @(posedge clk) begin
    irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed scoreboard bench for uart_fifo_bridge with a simple UART transmitter model.
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       io_addr;
  logic       io_rd;
  logic       io_wr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic [7:0] rx_byte;
  logic       received;
  logic       recv_error;
  logic       is_transmitting;
  logic [7:0] tx_byte;
  logic       transmit;
  logic       irq;

  always #5 clk = ~clk;

  uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .rx_byte(rx_byte),
    .received(received), .recv_error(recv_error),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte),
    .transmit(transmit), .irq(irq)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] tx_seen[$];
  int tx_busy_viol = 0;
  int uart_hold    = 40;
  int uart_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: busy for uart_hold cycles after each transmit request.
  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit === 1'b1) begin
        if (is_transmitting) tx_busy_viol++;
        tx_seen.push_back(tx_byte);
        is_transmitting = 1'b1;
        uart_cnt = uart_hold;
      end else if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) is_transmitting = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d);
    @(negedge clk);
    io_addr = a;
    io_rd   = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
    d = io_rdata;
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    @(negedge clk);
    io_addr  = a;
    io_wdata = d;
    io_wr    = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic read_data_check(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'h00;
    cpu_read(1'b0, d);
    check(tag, d, e);
  endtask

  task automatic read_status_check(input string tag, input logic [7:0] e);
    logic [7:0] d;
    cpu_read(1'b1, d);
    check(tag, d, e);
  endtask

  task automatic rx_pulse(input logic [7:0] b, input logic expect_kept);
    @(negedge clk);
    rx_byte  = b;
    received = 1'b1;
    @(negedge clk);
    received = 1'b0;
    if (expect_kept) rx_exp.push_back(b);
  endtask

  task automatic wait_tx(input string tag, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (tx_seen.size() >= n && !is_transmitting) break;
      @(negedge clk);
    end
    check(tag, (tx_seen.size() >= n && !is_transmitting) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic compare_tx(input string tag);
    check({tag, "_count"}, tx_seen.size(), tx_exp.size());
    while (tx_exp.size() > 0 && tx_seen.size() > 0) begin
      check(tag, tx_seen.pop_front(), tx_exp.pop_front());
    end
    tx_exp.delete();
    tx_seen.delete();
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b1; io_addr = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_wdata = 8'h00;
    rx_byte = 8'h00; received = 1'b0; recv_error = 1'b0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);

    check("reset_rdata", io_rdata, 8'h00);
    check("reset_transmit", transmit, 1'b0);
    check("reset_tx_byte", tx_byte, 8'h00);
    check("reset_irq", irq, 1'b0);
    read_status_check("reset_status", 8'h12);
    read_data_check("reset_data_empty");

    // Two received bytes
    rx_pulse(8'h41, 1'b1);
    rx_pulse(8'h42, 1'b1);
    read_status_check("status_rx_avail", 8'h13);
    read_data_check("rx_first");
    read_data_check("rx_second");
    read_status_check("status_rx_drained", 8'h12);

    // Overrun: 17 bytes into a 16-deep FIFO
    for (int i = 1; i <= 17; i++) rx_pulse(8'(i), (i <= 16) ? 1'b1 : 1'b0);
    read_status_check("status_overrun", 8'h17);
    read_status_check("status_overrun_cleared", 8'h13);
    for (int i = 0; i < 16; i++) read_data_check("rx_fill_order");
    read_status_check("status_after_fill", 8'h12);
    read_data_check("rx_empty_read");

    // Receive error sticky flag
    @(negedge clk);
    recv_error = 1'b1;
    @(negedge clk);
    recv_error = 1'b0;
    read_status_check("status_rx_error", 8'h1A);
    read_status_check("status_rx_error_cleared", 8'h12);

    // Full FIFO with simultaneous receive and pop
    for (int i = 0; i < 16; i++) rx_pulse(8'h80 + 8'(i), 1'b1);
    @(negedge clk);
    rx_byte = 8'h90; received = 1'b1; io_addr = 1'b0; io_rd = 1'b1;
    @(negedge clk);
    received = 1'b0; io_rd = 1'b0;
    d = io_rdata;
    check("simul_pop_data", d, rx_exp.pop_front());
    rx_exp.push_back(8'h90);
    read_status_check("simul_no_overrun", 8'h13);
    for (int i = 0; i < 16; i++) read_data_check("simul_order");
    read_status_check("simul_drained", 8'h12);

    // Two bytes transmitted through the launcher
    cpu_write(1'b0, 8'h55);
    tx_exp.push_back(8'h55);
    check("tx_not_immediate", transmit, 1'b0);
    cpu_write(1'b0, 8'hAA);
    tx_exp.push_back(8'hAA);
    wait_tx("tx_two_done", 2, 400);
    compare_tx("tx_two");
    check("tx_busy_violations", tx_busy_viol, 0);
    cycles(2);
    read_status_check("status_tx_done", 8'h12);

    // TX overflow: 18 writes while UART is held busy
    uart_hold = 300;
    for (int i = 0; i < 18; i++) begin
      cpu_write(1'b0, 8'hC0 + 8'(i));
      if (i <= 16) tx_exp.push_back(8'hC0 + 8'(i));
    end
    read_status_check("status_tx_overflow", 8'h20);
    read_status_check("status_tx_overflow_cleared", 8'h00);
    uart_hold = 6;
    wait_tx("tx_many_done", 17, 6000);
    compare_tx("tx_many");
    check("tx_busy_violations_many", tx_busy_viol, 0);
    cycles(2);
    read_status_check("status_tx_many_done", 8'h12);

    // Interrupt behaviour
    uart_hold = 40;
    cpu_write(1'b1, 8'h01);
    rx_pulse(8'h5A, 1'b1);
    cycles(2);
`ifdef UART_BRIDGE_IRQ_EN
    check("irq_rx_set", irq, 1'b1);
`else
    check("irq_rx_disabled", irq, 1'b0);
`endif
    read_data_check("irq_rx_data");
    cycles(2);
    check("irq_rx_cleared", irq, 1'b0);
    cpu_write(1'b1, 8'h02);
    cycles(2);
`ifdef UART_BRIDGE_IRQ_EN
    check("irq_tx_idle", irq, 1'b1);
`else
    check("irq_tx_disabled", irq, 1'b0);
`endif
    cpu_write(1'b1, 8'h00);
    cycles(2);
    check("irq_off", irq, 1'b0);
    read_status_check("status_after_ctrl", 8'h12);

    // Reset in the middle of buffered traffic
    rx_pulse(8'h11, 1'b0);
    rx_pulse(8'h22, 1'b0);
    cpu_write(1'b0, 8'h33);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx_byte", tx_byte, 8'h00);
    check("midrst_transmit", transmit, 1'b0);
    read_data_check("midrst_data_empty");
    tx_seen.delete();
    wait_tx("midrst_uart_settle", 0, 200);
    cycles(2);
    read_status_check("midrst_status", 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
